vec_cmd_issuer: RTL and testbench

Synthesizable host-side master for the vector accelerator `top` command interface. It accepts one command at a time from an upstream valid/ready port and drives the accelerator's addr/op/scalar/data/v_i lines. It waits for done_o, captures read data via v_o/yumi_i, and returns one response per command upstream. It replaces the task-driven stimulus used in simulation, so software or a larger SoC can sequence write/read/ALU operations.

---
 rtl/vec_pkg.sv | 36 +++
 rtl/vec_cmd_issuer_if.sv | 75 +++++++
 rtl/vec_cmd_issuer.sv | 150 +++++++++++++++
 tb/tb_vec_cmd_issuer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector-accelerator command issuer.
//   - opcode constants for write/read and the ALU function field
//   - bit index of the "use scalar operand" flag in ALU opcodes
//   - issuer FSM state encoding
//   - op_legal(): classifies a 4-bit opcode as legal or illegal
//   - safe_clog2(): address width that never collapses to zero bits
package vec_pkg;

  localparam logic [3:0] OP_WRITE = 4'b1001;
  localparam logic [3:0] OP_READ  = 4'b1000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;

  localparam int SCALAR_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Bit 3 set: only the write and read encodings exist.
  // Bit 3 clear: ALU op; function field 2'b11 is unassigned.
  function automatic logic op_legal(input logic [3:0] op);
    if (op[3]) return (op == OP_WRITE) || (op == OP_READ);
    return (op[1:0] == ALU_ADD) || (op[1:0] == ALU_SUB) || (op[1:0] == ALU_MUL);
  endfunction

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_cmd_issuer_if.sv
// vec_cmd_issuer_if: bundles the three buses of the command issuer.
//   cmd_*  : upstream command port (valid/ready), issuer is the sink
//   acc_*  : accelerator command/data lines, issuer is the driver
//   resp_* : upstream response port (valid/ready), issuer is the source
// Signal names are written from the issuer's point of view (_i = into the
// issuer, _o = out of it).
// modport master : the issuer itself
// modport slave  : the environment (host + accelerator) around it
//
// Handshake rule for cmd/resp/acc_v-ready: a transfer happens on a rising
// clock edge where valid and ready are both high; a source holds valid and
// its payload stable until that edge, and valid never depends on ready.
interface vec_cmd_issuer_if
  import vec_pkg::*;
#(
  parameter int els_p       = 8,
  parameter int vlen_p      = 4,
  parameter int vdw_p       = 4,
  parameter int cnt_width_p = 16
);
  localparam int addr_w_lp = safe_clog2(els_p);
  localparam int data_w_lp = vlen_p * vdw_p;

  logic                   cmd_v_i;
  logic                   cmd_ready_o;
  logic [3:0]             cmd_op_i;
  logic [addr_w_lp-1:0]   cmd_addrA_i;
  logic [addr_w_lp-1:0]   cmd_addrB_i;
  logic [addr_w_lp-1:0]   cmd_addrC_i;
  logic [vdw_p-1:0]       cmd_scalar_i;
  logic [data_w_lp-1:0]   cmd_data_i;

  logic [3:0]             acc_op_o;
  logic [addr_w_lp-1:0]   acc_addrA_o;
  logic [addr_w_lp-1:0]   acc_addrB_o;
  logic [addr_w_lp-1:0]   acc_addrC_o;
  logic [vdw_p-1:0]       acc_scalar_o;
  logic [data_w_lp-1:0]   acc_w_data_o;
  logic                   acc_v_o;
  logic                   acc_ready_i;
  logic                   acc_done_i;
  logic [data_w_lp-1:0]   acc_r_data_i;
  logic                   acc_rv_i;
  logic                   acc_yumi_o;

  logic                   resp_v_o;
  logic                   resp_ready_i;
  logic [data_w_lp-1:0]   resp_data_o;
  logic [3:0]             resp_op_o;
  logic                   resp_err_o;
  logic [cnt_width_p-1:0] resp_cycles_o;

  modport master (
    input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_data_i,
    output cmd_ready_o,
    output acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_scalar_o,
           acc_w_data_o, acc_v_o, acc_yumi_o,
    input  acc_ready_i, acc_done_i, acc_r_data_i, acc_rv_i,
    output resp_v_o, resp_data_o, resp_op_o, resp_err_o, resp_cycles_o,
    input  resp_ready_i
  );

  modport slave (
    output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_data_i,
    input  cmd_ready_o,
    input  acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_scalar_o,
           acc_w_data_o, acc_v_o, acc_yumi_o,
    output acc_ready_i, acc_done_i, acc_r_data_i, acc_rv_i,
    input  resp_v_o, resp_data_o, resp_op_o, resp_err_o, resp_cycles_o,
    output resp_ready_i
  );

endinterface

// File: rtl/vec_cmd_issuer.sv
// vec_cmd_issuer: host-side master for the vector accelerator command port.
// Accepts one command at a time, issues it to the accelerator, waits for
// completion (capturing read data), then returns one response upstream.
// Ports:
//   clk_i       : clock
//   reset_i     : asynchronous active-high reset
//   bus         : vec_cmd_issuer_if.master (cmd / acc / resp buses)
//   busy_o      : high whenever the FSM is not idle
//   dbg_state_o : current FSM state, for observation only
module vec_cmd_issuer
  import vec_pkg::*;
#(
  parameter int els_p       = 8,
  parameter int vlen_p      = 4,
  parameter int vdw_p       = 4,
  parameter int cnt_width_p = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  vec_cmd_issuer_if.master bus,
  output logic             busy_o,
  output state_e           dbg_state_o
);

  localparam int addr_w_lp = safe_clog2(els_p);
  localparam int data_w_lp = vlen_p * vdw_p;

  state_e                 r_state;
  logic                   r_cmd_ready;
  logic                   r_acc_v;
  logic                   r_resp_v;
  logic                   r_busy;
  logic [3:0]             r_op;
  logic [addr_w_lp-1:0]   r_addr_a;
  logic [addr_w_lp-1:0]   r_addr_b;
  logic [addr_w_lp-1:0]   r_addr_c;
  logic [vdw_p-1:0]       r_scalar;
  logic [data_w_lp-1:0]   r_w_data;
  logic [data_w_lp-1:0]   r_r_data;
  logic                   r_got_rv;
  logic                   r_err;
  logic [cnt_width_p-1:0] r_cnt;

  logic                   w_is_read;
  logic                   w_yumi;
  logic [cnt_width_p-1:0] w_cnt_next;

  assign w_is_read  = (r_op == OP_READ);
  assign w_yumi     = (r_state == ST_WAIT) && w_is_read && bus.acc_rv_i;
  // Latency counter saturates at all-ones instead of wrapping.
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + cnt_width_p'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_acc_v     <= 1'b0;
      r_resp_v    <= 1'b0;
      r_busy      <= 1'b0;
      r_op        <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      r_scalar    <= '0;
      r_w_data    <= '0;
      r_r_data    <= '0;
      r_got_rv    <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_v_i) begin
            r_op        <= bus.cmd_op_i;
            r_addr_a    <= bus.cmd_addrA_i;
            r_addr_b    <= bus.cmd_addrB_i;
            r_addr_c    <= bus.cmd_addrC_i;
            r_scalar    <= bus.cmd_scalar_i;
            r_w_data    <= bus.cmd_data_i;
            r_r_data    <= '0;
            r_got_rv    <= 1'b0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (op_legal(bus.cmd_op_i)) begin
              r_err   <= 1'b0;
              r_acc_v <= 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              // Illegal opcodes never reach the accelerator.
              r_err    <= 1'b1;
              r_resp_v <= 1'b1;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt <= w_cnt_next;
          if (bus.acc_ready_i) begin
            r_acc_v <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_next;
          if (w_yumi) begin
            r_r_data <= bus.acc_r_data_i;
            r_got_rv <= 1'b1;
          end
          if (bus.acc_done_i) begin
            // A read that never produced a valid beat returns whatever the
            // data lines carry on the done cycle.
            if (w_is_read && !r_got_rv) r_r_data <= bus.acc_r_data_i;
            r_resp_v <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready_i) begin
            r_resp_v    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o   = r_cmd_ready;
  assign bus.acc_op_o      = r_op;
  assign bus.acc_addrA_o   = r_addr_a;
  assign bus.acc_addrB_o   = r_addr_b;
  assign bus.acc_addrC_o   = r_addr_c;
  assign bus.acc_scalar_o  = r_scalar;
  assign bus.acc_w_data_o  = r_w_data;
  assign bus.acc_v_o       = r_acc_v;
  assign bus.acc_yumi_o    = w_yumi;
  assign bus.resp_v_o      = r_resp_v;
  assign bus.resp_data_o   = r_r_data;
  assign bus.resp_op_o     = r_op;
  assign bus.resp_err_o    = r_err;
  assign bus.resp_cycles_o = r_cnt;
  assign busy_o            = r_busy;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// tb_vec_cmd_issuer: directed bench for vec_cmd_issuer. The bench plays both
// the upstream host and the accelerator (a small register-file model), and
// checks every response against hand-computed values.
module tb_vec_cmd_issuer;
  import vec_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   busy;
  state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] model [8];

  vec_cmd_issuer_if bus ();

  vec_cmd_issuer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .bus         (bus),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [3:0] s);
    logic [15:0] r;
    logic [3:0]  x, y;
    r = '0;
    for (int e = 0; e < 4; e++) begin
      x = a[e*4 +: 4];
      y = op[SCALAR_BIT] ? s : b[e*4 +: 4];
      case (op[1:0])
        ALU_ADD: r[e*4 +: 4] = x + y;
        ALU_SUB: r[e*4 +: 4] = x - y;
        default: r[e*4 +: 4] = x * y;
      endcase
    end
    return r;
  endfunction

  // One full command: host send, accelerator service, response check.
  // rv_mode for reads: 0 = no valid beat (data on done cycle),
  // 1 = valid beat coincides with done, 2 = valid beat one cycle before done.
  task automatic run_cmd(input string tag, input logic [3:0] op,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic [3:0] s, input logic [15:0] d, input int stall,
                         input int rv_mode, input logic [15:0] exp_data);
    logic [15:0] rdat;
    logic [35:0] exp_fields;
    int          exp_cycles;
    int          wait_n;
    bit          is_rd;
    is_rd = (op == OP_READ);
    exp_cycles = stall + 2 + ((is_rd && rv_mode == 2) ? 1 : 0);
    exp_fields = {1'b1, op, a, b, c, s, d};

    @(negedge clk);
    check({tag, ".cmd_ready"}, bus.cmd_ready_o, 1);
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = op;
    bus.cmd_addrA_i = a; bus.cmd_addrB_i = b; bus.cmd_addrC_i = c;
    bus.cmd_scalar_i = s; bus.cmd_data_i = d;
    @(negedge clk);
    bus.cmd_v_i = 1'b0;
    bus.cmd_data_i = 16'h0; bus.cmd_op_i = 4'h0;

    wait_n = 0;
    while (bus.acc_v_o !== 1'b1 && wait_n < 20) begin
      @(negedge clk); wait_n++;
    end
    check({tag, ".issue"}, {bus.acc_v_o, bus.acc_op_o, bus.acc_addrA_o, bus.acc_addrB_o,
          bus.acc_addrC_o, bus.acc_scalar_o, bus.acc_w_data_o}, exp_fields);

    bus.acc_ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall"}, {bus.acc_v_o, bus.acc_op_o, bus.acc_addrA_o, bus.acc_addrB_o,
            bus.acc_addrC_o, bus.acc_scalar_o, bus.acc_w_data_o}, exp_fields);
    end
    bus.acc_ready_i = 1'b1;
    @(negedge clk);
    bus.acc_ready_i = 1'b0;
    check({tag, ".acc_v_drop"}, bus.acc_v_o, 0);

    // accelerator side effect
    rdat = model[a];
    if (op == OP_WRITE) model[c] = d;
    else if (!is_rd) model[c] = alu(op, model[a], model[b], s);

    if (is_rd && rv_mode == 2) begin
      bus.acc_rv_i = 1'b1; bus.acc_r_data_i = rdat;
      #1 check({tag, ".yumi_early"}, bus.acc_yumi_o, 1);
      @(negedge clk);
      bus.acc_rv_i = 1'b0; bus.acc_r_data_i = 16'hDEAD;
    end
    bus.acc_done_i = 1'b1;
    if (is_rd) begin
      bus.acc_r_data_i = rdat;
      bus.acc_rv_i = (rv_mode == 1);
      #1 check({tag, ".yumi"}, bus.acc_yumi_o, (rv_mode == 1) ? 1 : 0);
    end else begin
      bus.acc_r_data_i = 16'hBEEF;
      bus.acc_rv_i = 1'b1;
      #1 check({tag, ".yumi_nonread"}, bus.acc_yumi_o, 0);
    end
    @(negedge clk);
    bus.acc_done_i = 1'b0; bus.acc_rv_i = 1'b0; bus.acc_r_data_i = 16'h5A5A;

    check({tag, ".resp_v"}, {bus.resp_v_o, bus.cmd_ready_o, busy}, 3'b101);
    check({tag, ".resp_data"}, bus.resp_data_o, exp_data);
    check({tag, ".resp_op_err"}, {bus.resp_op_o, bus.resp_err_o}, {op, 1'b0});
    check({tag, ".resp_cycles"}, bus.resp_cycles_o, exp_cycles);
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check({tag, ".back_idle"}, {bus.resp_v_o, bus.cmd_ready_o, busy}, 3'b010);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addrA_i = '0; bus.cmd_addrB_i = '0;
    bus.cmd_addrC_i = '0; bus.cmd_scalar_i = '0; bus.cmd_data_i = '0;
    bus.acc_ready_i = 1'b0; bus.acc_done_i = 1'b0; bus.acc_r_data_i = '0;
    bus.acc_rv_i = 1'b0; bus.resp_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;

    // reset values
    @(negedge clk);
    check("reset.ctrl", {bus.cmd_ready_o, bus.acc_v_o, bus.acc_yumi_o, bus.resp_v_o, busy},
          5'b10000);
    check("reset.data", {bus.resp_data_o, bus.resp_op_o, bus.resp_err_o, bus.resp_cycles_o,
          bus.acc_op_o, bus.acc_w_data_o}, '0);
    @(negedge clk);
    reset = 1'b0;

    run_cmd("wr_r1",  OP_WRITE, 3'd0, 3'd0, 3'd1, 4'h0, 16'h0101, 0, 0, 16'h0000);
    run_cmd("wr_r2",  OP_WRITE, 3'd0, 3'd0, 3'd2, 4'h0, 16'h1144, 0, 0, 16'h0000);
    run_cmd("add_r0", 4'b0000,  3'd1, 3'd2, 3'd0, 4'h0, 16'h0000, 0, 0, 16'h0000);
    run_cmd("rd_r0",  OP_READ,  3'd0, 3'd0, 3'd0, 4'h0, 16'h0000, 0, 1, 16'h1245);
    run_cmd("sub_r3", 4'b0001,  3'd2, 3'd1, 3'd3, 4'h0, 16'h0000, 3, 0, 16'h0000);
    run_cmd("rd_r3",  OP_READ,  3'd3, 3'd0, 3'd0, 4'h0, 16'h0000, 0, 2, 16'h1043);
    run_cmd("mul_r5", 4'b0010,  3'd1, 3'd3, 3'd5, 4'h0, 16'h0000, 0, 0, 16'h0000);
    run_cmd("rd_r5",  OP_READ,  3'd5, 3'd0, 3'd0, 4'h0, 16'h0000, 1, 0, 16'h0003);
    run_cmd("adds_r4", 4'b0100, 3'd1, 3'd0, 3'd4, 4'h2, 16'h0000, 0, 0, 16'h0000);
    run_cmd("rd_r4",  OP_READ,  3'd4, 3'd0, 3'd0, 4'h0, 16'h0000, 0, 1, 16'h2323);

    // illegal ALU opcode: straight to an error response, nothing issued
    @(negedge clk);
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = 4'b0011;
    @(negedge clk);
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = 4'h0;
    check("ill.no_issue", bus.acc_v_o, 0);
    check("ill.resp", {bus.resp_v_o, bus.resp_err_o, bus.resp_op_o, bus.resp_data_o,
          bus.resp_cycles_o}, {1'b1, 1'b1, 4'b0011, 16'h0, 16'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ill.hold", {bus.resp_v_o, bus.resp_err_o, bus.resp_op_o, bus.resp_data_o,
            bus.cmd_ready_o, bus.acc_v_o}, {1'b1, 1'b1, 4'b0011, 16'h0, 1'b0, 1'b0});
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check("ill.release", {bus.resp_v_o, bus.cmd_ready_o}, 2'b01);

    // illegal opcode with bit 3 set
    @(negedge clk);
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = 4'b1010;
    @(negedge clk);
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = 4'h0;
    check("ill2.resp", {bus.acc_v_o, bus.resp_v_o, bus.resp_err_o, bus.resp_op_o},
          {1'b0, 1'b1, 1'b1, 4'b1010});
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;

    // async reset while waiting on the accelerator
    @(negedge clk);
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = OP_READ; bus.cmd_addrA_i = 3'd1;
    @(negedge clk);
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = 4'h0; bus.cmd_addrA_i = '0;
    bus.acc_ready_i = 1'b1;
    @(negedge clk);
    bus.acc_ready_i = 1'b0;
    check("rst.in_wait", dbg_state, ST_WAIT);
    #2 reset = 1'b1;
    #1;
    check("rst.ctrl", {bus.cmd_ready_o, bus.acc_v_o, bus.resp_v_o, busy, dbg_state},
          {4'b1000, ST_IDLE});
    check("rst.fields", {bus.acc_op_o, bus.acc_addrA_o, bus.resp_op_o, bus.resp_cycles_o}, '0);
    @(negedge clk);
    reset = 1'b0;

    run_cmd("wr_r6", OP_WRITE, 3'd0, 3'd0, 3'd6, 4'h0, 16'hABCD, 0, 0, 16'h0000);
    run_cmd("rd_r6", OP_READ,  3'd6, 3'd0, 3'd0, 4'h0, 16'h0000, 0, 1, 16'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
